// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl
// -------------
// Run/step sequencer for the CPU core. It debounces the board step and run
// buttons and turns them into the core's `step` clock-enable. Four modes are
// supported: single step, burst of N steps, free run, and halt on a PC
// breakpoint.
//
// Optional feature macro: CPU_STEP_CNT_EN
//   defined   -> step_count counts every cycle with step=1 (wraps at 2^32)
//   undefined -> no counter is built and step_count is constant 0
//
// Ports
//   clk        in   system clock, rising edge
//   resetn     in   synchronous active-low reset
//   btn_step   in   raw step button (asynchronous, bouncy)
//   btn_run    in   raw run/stop toggle button (asynchronous, bouncy)
//   burst_len  in   steps per step press, 0 means a single step
//   bp_en      in   breakpoint enable
//   bp_pc      in   breakpoint address
//   core_pc    in   PC of the core's next instruction
//   step       out  clock enable to the core (combinational)
//   state      out  00 IDLE, 01 BURST, 10 RUN, 11 BP_HALT
//   bp_hit     out  registered, high while in BP_HALT
//   step_count out  step cycles issued since reset
//
// Handshake: there is no valid/ready pair here. `step` is a plain qualifier:
// the core advances exactly on the rising edges that see step=1, and core_pc
// only changes after such an edge.

module cpu_step_ctrl #(
  parameter int DB_TICKS = 1000000,
  parameter int DB_CNT_W = 20,
  parameter int BURST_W  = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               btn_step,
  input  logic               btn_run,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               bp_en,
  input  logic [31:0]        bp_pc,
  input  logic [31:0]        core_pc,
  output logic               step,
  output logic [1:0]         state,
  output logic               bp_hit,
  output logic [31:0]        step_count
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_BURST = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;
  localparam logic [1:0] S_HALT  = 2'b11;

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_TICKS - 1);

  // ---------------------------------------------------------------------------
  // Debounce, index 0 = step button, index 1 = run button
  // ---------------------------------------------------------------------------
  logic [1:0]               raw;
  logic [1:0]               sync1;
  logic [1:0]               sync2;
  logic [1:0]               db_level;
  logic [1:0]               press;
  logic [1:0][DB_CNT_W-1:0] db_cnt;

  assign raw = {btn_run, btn_step};

  // db_cnt measures how many consecutive cycles the synchronized input has
  // disagreed with the accepted level. Any cycle where they agree (a bounce
  // back) restarts the measurement, so a new level is accepted only after it
  // has held for DB_TICKS cycles. The press pulse is produced on the same edge
  // the level rises, so it lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1    <= '0;
      sync2    <= '0;
      db_level <= '0;
      press    <= '0;
      db_cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_level[i] <= sync2[i];
          db_cnt[i]   <= '0;
          press[i]    <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_CNT_W'(1);
        end
      end
    end
  end

  logic step_press;
  logic run_press;

  assign step_press = press[0];
  assign run_press  = press[1];

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [BURST_W-1:0] burst_cnt;
  logic [BURST_W-1:0] burst_cnt_d;
  logic [BURST_W-1:0] burst_load;
  logic               bp_skip;
  logic               bp_skip_d;
  logic               bp_hit_q;
  logic               match;
  logic               step_int;

  // bp_skip masks the compare for the one step that moves the core off the
  // breakpoint instruction after resuming from BP_HALT.
  assign match = bp_en & (core_pc == bp_pc) & ~bp_skip;

  // A run press stops the core in the press cycle itself, so it also gates
  // step in BURST and RUN.
  assign step_int = ((state_q == S_RUN) | (state_q == S_BURST)) & ~match & ~run_press;

  assign burst_load = (burst_len == '0) ? BURST_W'(1) : burst_len;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt;
    bp_skip_d   = bp_skip & ~step_int;
    case (state_q)
      S_IDLE: begin
        if (run_press) begin
          state_d = S_RUN;
        end else if (step_press) begin
          state_d     = S_BURST;
          burst_cnt_d = burst_load;
        end
      end
      S_BURST: begin
        if (run_press) begin
          state_d     = S_IDLE;
          burst_cnt_d = '0;
        end else if (match) begin
          state_d     = S_HALT;
          burst_cnt_d = '0;
        end else begin
          // step_int is 1 on this path
          burst_cnt_d = burst_cnt - BURST_W'(1);
          if (burst_cnt == BURST_W'(1)) begin
            state_d = S_IDLE;
          end
        end
      end
      S_RUN: begin
        if (run_press) begin
          state_d = S_IDLE;
        end else if (match) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (run_press) begin
          state_d   = S_RUN;
          bp_skip_d = 1'b1;
        end else if (step_press) begin
          state_d     = S_BURST;
          burst_cnt_d = burst_load;
          bp_skip_d   = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      burst_cnt <= '0;
      bp_skip   <= 1'b0;
      bp_hit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_cnt <= burst_cnt_d;
      bp_skip   <= bp_skip_d;
      bp_hit_q  <= (state_d == S_HALT);
    end
  end

  assign step   = step_int;
  assign state  = state_q;
  assign bp_hit = bp_hit_q;

  // ---------------------------------------------------------------------------
  // Step counter
  // ---------------------------------------------------------------------------
`ifdef CPU_STEP_CNT_EN
  logic [31:0] step_cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      step_cnt_q <= '0;
    end else if (step_int) begin
      step_cnt_q <= step_cnt_q + 32'd1;
    end
  end

  assign step_count = step_cnt_q;
`else
  assign step_count = 32'h0;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl with short debounce (DB_TICKS=4).
// A small core stand-in advances core_pc by 4 on every edge with step=1.
// A behavioural model (button run-length debounce + mode/remaining-steps
// bookkeeping) predicts step/state/bp_hit/step_count every cycle; directed
// scenarios add hand-computed literal expectations.

module tb_cpu_step_ctrl;

  localparam int DB_TICKS = 4;
  localparam int DB_CNT_W = 3;
  localparam int BURST_W  = 8;

  localparam int M_IDLE  = 0;
  localparam int M_BURST = 1;
  localparam int M_RUN   = 2;
  localparam int M_HALT  = 3;

  // ---------------------------------------------------------------- clock/reset
  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               btn_step = 1'b0;
  logic               btn_run = 1'b0;
  logic [BURST_W-1:0] burst_len = '0;
  logic               bp_en = 1'b0;
  logic [31:0]        bp_pc = '0;
  logic [31:0]        core_pc;
  logic               step;
  logic [1:0]         state;
  logic               bp_hit;
  logic [31:0]        step_count;

  logic pc_load = 1'b1;
  logic check_en = 1'b0;

  always #5 clk = ~clk;

  cpu_step_ctrl #(
    .DB_TICKS(DB_TICKS),
    .DB_CNT_W(DB_CNT_W),
    .BURST_W (BURST_W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .btn_step  (btn_step),
    .btn_run   (btn_run),
    .burst_len (burst_len),
    .bp_en     (bp_en),
    .bp_pc     (bp_pc),
    .core_pc   (core_pc),
    .step      (step),
    .state     (state),
    .bp_hit    (bp_hit),
    .step_count(step_count)
  );

  // Core stand-in: next-instruction PC advances after each stepped edge.
  initial forever begin
    @(posedge clk);
    if (pc_load) core_pc <= 32'h0;
    else if (step) core_pc <= core_pc + 32'd4;
  end

  // ---------------------------------------------------------------- scoreboard
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef CPU_STEP_CNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  // ---------------------------------------------------------------- model
  int          m_mode = M_IDLE;
  int          m_left = 0;
  bit          m_skip = 1'b0;
  bit          m_sp = 1'b0;
  bit          m_rp = 1'b0;
  int unsigned m_count = 0;
  bit          db_lvl[2];
  int          db_run[2];
  bit          hs_q[$];
  bit          hr_q[$];

  function automatic bit model_match();
    return bp_en && (core_pc == bp_pc) && !m_skip;
  endfunction

  function automatic bit model_step();
    return (m_mode == M_BURST || m_mode == M_RUN) && !model_match() && !m_rp;
  endfunction

  // A button level flips after DB_TICKS consecutive edges on which the
  // (two-edge delayed) raw sample disagrees with the accepted level.
  task automatic db_update(input int idx, input bit v, output bit p);
    p = 1'b0;
    if (v != db_lvl[idx]) begin
      db_run[idx]++;
      if (db_run[idx] == DB_TICKS) begin
        db_lvl[idx] = v;
        db_run[idx] = 0;
        p = v;
      end
    end else begin
      db_run[idx] = 0;
    end
  endtask

  initial forever begin
    bit st;
    bit mt;
    bit vs;
    bit vr;
    @(posedge clk);
    if (!resetn) begin
      m_mode = M_IDLE; m_left = 0; m_skip = 1'b0; m_sp = 1'b0; m_rp = 1'b0;
      m_count = 0;
      db_lvl[0] = 1'b0; db_lvl[1] = 1'b0; db_run[0] = 0; db_run[1] = 0;
      hs_q = '{1'b0, 1'b0};
      hr_q = '{1'b0, 1'b0};
    end else begin
      st = model_step();
      mt = model_match();
      if (st) m_count++;
      if (st) m_skip = 1'b0;
      case (m_mode)
        M_IDLE: begin
          if (m_rp) m_mode = M_RUN;
          else if (m_sp) begin
            m_mode = M_BURST;
            m_left = (burst_len == 0) ? 1 : int'(burst_len);
          end
        end
        M_BURST: begin
          if (m_rp) m_mode = M_IDLE;
          else if (mt) m_mode = M_HALT;
          else begin
            m_left--;
            if (m_left == 0) m_mode = M_IDLE;
          end
        end
        M_RUN: begin
          if (m_rp) m_mode = M_IDLE;
          else if (mt) m_mode = M_HALT;
        end
        default: begin
          if (m_rp) begin
            m_mode = M_RUN;
            m_skip = 1'b1;
          end else if (m_sp) begin
            m_mode = M_BURST;
            m_left = (burst_len == 0) ? 1 : int'(burst_len);
            m_skip = 1'b1;
          end
        end
      endcase
      vs = hs_q.pop_front();
      hs_q.push_back(btn_step);
      vr = hr_q.pop_front();
      hr_q.push_back(btn_run);
      db_update(0, vs, m_sp);
      db_update(1, vr, m_rp);
    end
  end

  // ---------------------------------------------------------------- compare
  int pulses = 0;
  int burst_cyc = 0;
  int cur_run = 0;
  int last_run = 0;

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      check("step", {31'b0, step}, {31'b0, model_step()});
      check("state", {30'b0, state}, 32'(m_mode));
      check("bp_hit", {31'b0, bp_hit}, {31'b0, (m_mode == M_HALT)});
      check("step_count", step_count, cnt_exp(int'(m_count)));
      if (step === 1'b1) begin
        pulses++;
        cur_run++;
      end else if (cur_run != 0) begin
        last_run = cur_run;
        cur_run = 0;
      end
      if (state === 2'b01) burst_cyc++;
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    pc_load = 1'b1;
    tick();
    tick();
    resetn = 1'b1;
    pc_load = 1'b0;
    tick();
  endtask

  task automatic press(input bit which);
    if (which) btn_run = 1'b1;
    else btn_step = 1'b1;
    repeat (10) tick();
    btn_run = 1'b0;
    btn_step = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- main
  initial begin
    int p0;
    int b0;
    int waited;

    repeat (3) tick();
    resetn = 1'b1;
    pc_load = 1'b0;
    check_en = 1'b1;
    tick();
    check("reset_state", {30'b0, state}, 32'h0);
    check("reset_step", {31'b0, step}, 32'h0);
    check("reset_bp_hit", {31'b0, bp_hit}, 32'h0);
    check("reset_count", step_count, 32'h0);

    // 1: bouncy step button -> exactly one single step
    burst_len = 8'd0;
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      btn_step = ~btn_step;
      tick();
    end
    btn_step = 1'b1;
    repeat (12) tick();
    btn_step = 1'b0;
    repeat (12) tick();
    check("single_pulses", 32'(pulses - p0), 32'd1);
    check("single_count", step_count, cnt_exp(1));
    check("single_model_count", m_count, 32'd1);
    check("single_state", {30'b0, state}, 32'h0);

    // 2: burst of 5
    do_reset();
    burst_len = 8'd5;
    p0 = pulses;
    b0 = burst_cyc;
    press(1'b0);
    check("burst_pulses", 32'(pulses - p0), 32'd5);
    check("burst_run_len", 32'(last_run), 32'd5);
    check("burst_state_cycles", 32'(burst_cyc - b0), 32'd5);
    check("burst_pc", core_pc, 32'h14);
    check("burst_count", step_count, cnt_exp(5));
    check("burst_model_count", m_count, 32'd5);
    check("burst_state", {30'b0, state}, 32'h0);

    // 3: run into breakpoint at 0x20
    do_reset();
    bp_en = 1'b1;
    bp_pc = 32'h20;
    btn_run = 1'b1;
    waited = 0;
    while (state !== 2'b11 && waited < 100) begin
      tick();
      waited++;
    end
    check("bp_reached", {31'b0, (waited < 100)}, 32'd1);
    check("bp_state", {30'b0, state}, 32'h3);
    check("bp_hit", {31'b0, bp_hit}, 32'd1);
    check("bp_step_low", {31'b0, step}, 32'd0);
    check("bp_pc", core_pc, 32'h20);
    check("bp_count", step_count, cnt_exp(8));
    check("bp_model_count", m_count, 32'd8);
    btn_run = 1'b0;
    repeat (10) tick();
    check("bp_hold", {30'b0, state}, 32'h3);

    // 4: resume past the breakpoint, then stop
    press(1'b1);
    check("resume_state", {30'b0, state}, 32'h2);
    check("resume_bp_hit", {31'b0, bp_hit}, 32'd0);
    check("resume_past_bp", {31'b0, (core_pc > 32'h24)}, 32'd1);
    press(1'b1);
    check("stop_state", {30'b0, state}, 32'h0);
    check("stop_step", {31'b0, step}, 32'd0);

    // 5: both presses in the same cycle -> run wins
    do_reset();
    bp_en = 1'b0;
    burst_len = 8'd3;
    b0 = burst_cyc;
    btn_step = 1'b1;
    btn_run = 1'b1;
    repeat (10) tick();
    btn_step = 1'b0;
    btn_run = 1'b0;
    repeat (10) tick();
    check("both_state", {30'b0, state}, 32'h2);
    check("both_no_burst", 32'(burst_cyc - b0), 32'd0);

    // 6: reset during run at 37 steps
    do_reset();
    btn_run = 1'b1;
    repeat (10) tick();
    btn_run = 1'b0;
    waited = 0;
    while (m_count != 37 && waited < 200) begin
      tick();
      waited++;
    end
    check("run37_reached", {31'b0, (waited < 200)}, 32'd1);
    check("run37_count", step_count, cnt_exp(37));
    check("run37_state", {30'b0, state}, 32'h2);
    resetn = 1'b0;
    tick();
    check("rst_step", {31'b0, step}, 32'd0);
    check("rst_state", {30'b0, state}, 32'h0);
    resetn = 1'b1;
    tick();
    check("rst_count", step_count, 32'h0);
    p0 = pulses;
    repeat (5) tick();
    check("rst_no_pulses", 32'(pulses - p0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
